simple_dpram_be_sclk: RTL and testbench
=======================================

# simple_dpram_be_sclk

Single-clock simple dual-port RAM (one write port, one read port) with per-byte write enables, per-lane read-during-write bypass, an optional output pipeline register and a read-data valid flag. It is the storage element under the FIFO and buffering blocks wherever partial-word writes or a registered RAM output for timing closure are needed.

## Interface
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be an integer multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes.
- ENABLE_BYPASS, 1, 1 = a same-cycle same-address write is forwarded to the read result per lane; 0 = old memory contents are returned.
- OUT_REG, 0, 1 = one extra output register stage (read latency 2).
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- waddr  in  ADDR_WIDTH  write address.
- we  in  1  write strobe.
- wbe  in  NB  per-lane write enable; lane i covers din[i*BYTE_WIDTH +: BYTE_WIDTH].
- din  in  DATA_WIDTH  write data.
- raddr  in  ADDR_WIDTH  read address.
- re  in  1  read strobe.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  one-cycle pulse marking the cycle dout carries a new read result.

## Operation
- Write: on edge with we=1, each lane i with wbe[i]=1 takes its din lane at mem[waddr]; lanes with wbe[i]=0 keep their contents. we=1, wbe=0 writes nothing.
- Read: on edge with re=1, mem[raddr] is captured into stage 1. re=0: stage 1 holds, dout holds.
- Bypass (ENABLE_BYPASS=1): if re, we and raddr==waddr on the same edge, lane i of the result is din lane i where wbe[i]=1, else the old memory lane. Mask and din are registered with the read; merge is a per-lane mux after the registers. ENABLE_BYPASS=0: old word returned for all lanes.
- Write at edge N followed by read of the same address at edge N+1 always returns the new data, regardless of ENABLE_BYPASS.
- OUT_REG=1: stage-2 register loads the merged stage-1 result on the edge after any stage-1 capture; otherwise holds.
- dout_valid: OUT_REG=0 → registered copy of re; OUT_REG=1 → re delayed two edges. Back-to-back re gives back-to-back valids; no stalls, no backpressure.
- Reset (rst_n low, any time): dout=0, dout_valid=0, bypass mask=0, stage registers=0, in-flight reads discarded. Memory contents are not reset and are retained across reset. Writes and reads are ignored while rst_n is low.
- Out-of-range addresses cannot occur (depth is an exact power of two).

## Timing
- Read latency: 1 cycle (OUT_REG=0), 2 cycles (OUT_REG=1), from the edge sampling re to dout/dout_valid valid.
- Throughput: one read and one write per cycle, independent addresses.
- Write latency: 1 cycle; data visible to a read sampled on the next edge.
- No combinational path from any input to dout or dout_valid.
- Reset deassertion is synchronised externally; the first edge after deassertion may sample re/we.

## Configuration
- Macro SIMPLE_DPRAM_BE_PEEK_EN: when defined, adds ports peek_address (in, ADDR_WIDTH) and peek_data (out, DATA_WIDTH). peek_data = mem[peek_address] combinationally, zero latency, no bypass merge, for formal proofs and debug. When undefined the ports do not exist and behaviour is otherwise identical.

## Structure
- Shared package dpram_pkg: lane-count helper function (DATA_WIDTH/BYTE_WIDTH) and the elaboration check that DATA_WIDTH % BYTE_WIDTH == 0.
- One natural sub-module, dpram_lane_merge: combinational per-lane mux (registered mask, registered din, raw RAM word → merged word). Instantiated only when ENABLE_BYPASS=1.

## Test plan
- Full write then read: we, wbe=4'hF, waddr=5, din=32'hDEADBEEF; next cycle re, raddr=5 → one cycle later dout=32'hDEADBEEF, dout_valid=1 for one cycle.
- Partial write: mem[7]=32'h11223344, then write wbe=4'b0101, din=32'hAABBCCDD → read of 7 returns 32'h11BB33DD.
- Collision with bypass: mem[3]=32'h00000000; same edge we, wbe=4'b1000, waddr=3, din=32'hFF000000, re, raddr=3 → dout=32'hFF000000; ENABLE_BYPASS=0 → dout=32'h00000000; next read of 3 returns 32'hFF000000 in both cases.
- OUT_REG=1 streaming: re held high for 4 cycles over addresses 0..3 → dout_valid high on cycles 2..5, data in address order, no gaps.
- Hold: after a valid read, re=0 for 3 cycles with writes to the read address → dout unchanged, dout_valid=0.
- Reset mid-operation: assert rst_n low in the cycle after re with OUT_REG=1 → dout=0, dout_valid=0 immediately and no valid after release; a subsequent read returns the pre-reset memory contents.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared helpers for the byte-enable dual-port RAM family.
// lane_count gives the number of byte lanes in a word; lanes_fit is the
// elaboration-time check that a word splits into whole lanes.
package dpram_pkg;

    function automatic int lane_count(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic bit lanes_fit(input int data_width, input int byte_width);
        return (byte_width > 0) && ((data_width % byte_width) == 0);
    endfunction

endpackage

// File: rtl/dpram_lane_merge.sv
// Per-lane read-during-write merge: lanes flagged in the registered mask
// take the registered write data, all other lanes keep the RAM word.
module dpram_lane_merge
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [lane_count(DATA_WIDTH, BYTE_WIDTH)-1:0] mask,
    input  logic [DATA_WIDTH-1:0]                         wdata,
    input  logic [DATA_WIDTH-1:0]                         ram_word,
    output logic [DATA_WIDTH-1:0]                         merged
);

    localparam int NB = lane_count(DATA_WIDTH, BYTE_WIDTH);

    // Select write data or RAM data lane by lane
    always_comb begin
        merged = ram_word;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/simple_dpram_be_sclk.sv
// Single-clock simple dual-port RAM with per-byte write enables, optional
// per-lane read-during-write bypass, optional output register stage and a
// read-data valid pulse.
// Optional macro SIMPLE_DPRAM_BE_PEEK_EN adds a zero-latency debug read port
// (peek_address / peek_data) straight off the memory array.
module simple_dpram_be_sclk
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int ENABLE_BYPASS = 1,
    parameter int OUT_REG       = 0
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [ADDR_WIDTH-1:0]                        waddr,
    input  logic                                         we,
    input  logic [lane_count(DATA_WIDTH, BYTE_WIDTH)-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]                        din,
    input  logic [ADDR_WIDTH-1:0]                        raddr,
    input  logic                                         re,
    output logic [DATA_WIDTH-1:0]                        dout,
    output logic                                         dout_valid
`ifdef SIMPLE_DPRAM_BE_PEEK_EN
    ,
    input  logic [ADDR_WIDTH-1:0]                        peek_address,
    output logic [DATA_WIDTH-1:0]                        peek_data
`endif
);

    localparam int NB    = lane_count(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!lanes_fit(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
        $error("DATA_WIDTH must be an integer multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Writes are suppressed while reset is held so the array is left untouched
    logic write_ok;
    assign write_ok = we & rst_n;

    // Byte-lane write into the array; contents survive reset
    always_ff @(posedge clk) begin
        if (write_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ---- stage 1: raw RAM word captured on a read ----
    logic [DATA_WIDTH-1:0] rdata_p1;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] merged_p1;

    // Capture the addressed word on re; valid is a registered copy of re
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= re;
            if (re) begin
                rdata_p1 <= mem[raddr];
            end
        end
    end

    if (ENABLE_BYPASS != 0) begin : g_bypass
        logic [NB-1:0]         mask_p1;
        logic [DATA_WIDTH-1:0] din_p1;

        // Register the colliding-write lanes and data alongside the read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mask_p1 <= '0;
                din_p1  <= '0;
            end else if (re) begin
                mask_p1 <= (we && (waddr == raddr)) ? wbe : '0;
                din_p1  <= din;
            end
        end

        dpram_lane_merge #(
            .DATA_WIDTH (DATA_WIDTH),
            .BYTE_WIDTH (BYTE_WIDTH)
        ) u_lane_merge (
            .mask     (mask_p1),
            .wdata    (din_p1),
            .ram_word (rdata_p1),
            .merged   (merged_p1)
        );
    end else begin : g_no_bypass
        assign merged_p1 = rdata_p1;
    end

    // ---- stage 2: optional output register ----
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] dout_p2;
        logic                  vld_p2;

        // Reload from stage 1 on the edge after every stage-1 capture
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_p2 <= '0;
                vld_p2  <= 1'b0;
            end else begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    dout_p2 <= merged_p1;
                end
            end
        end

        assign dout       = dout_p2;
        assign dout_valid = vld_p2;
    end else begin : g_direct
        assign dout       = merged_p1;
        assign dout_valid = vld_p1;
    end

`ifdef SIMPLE_DPRAM_BE_PEEK_EN
    assign peek_data = mem[peek_address];
`endif

endmodule

// File: tb/tb_simple_dpram_be_sclk.sv
// Directed bench for simple_dpram_be_sclk. Three instances share one stimulus:
// a: bypass on, no output reg; b: bypass off, no output reg; c: bypass on, output reg.
module tb_simple_dpram_be_sclk;

    logic        clk;
    logic        rst_n;
    logic [7:0]  waddr;
    logic        we;
    logic [3:0]  wbe;
    logic [31:0] din;
    logic [7:0]  raddr;
    logic        re;
    logic [31:0] dout_a, dout_b, dout_c;
    logic        vld_a, vld_b, vld_c;

    int n_vec  = 0;
    int n_miss = 0;

    simple_dpram_be_sclk #(.ENABLE_BYPASS(1), .OUT_REG(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .we(we), .wbe(wbe), .din(din),
        .raddr(raddr), .re(re), .dout(dout_a), .dout_valid(vld_a)
    );

    simple_dpram_be_sclk #(.ENABLE_BYPASS(0), .OUT_REG(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .we(we), .wbe(wbe), .din(din),
        .raddr(raddr), .re(re), .dout(dout_b), .dout_valid(vld_b)
    );

    simple_dpram_be_sclk #(.ENABLE_BYPASS(1), .OUT_REG(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .we(we), .wbe(wbe), .din(din),
        .raddr(raddr), .re(re), .dout(dout_c), .dout_valid(vld_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] stream_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b0; wbe = 4'h0;
        waddr = 8'd0; raddr = 8'd0; din = 32'h0;
        tick(); tick();
        check_vec("rst_dout_a", dout_a, 32'h0);
        check_vec("rst_vld_a", 32'(vld_a), 32'h0);
        check_vec("rst_dout_c", dout_c, 32'h0);
        check_vec("rst_vld_c", 32'(vld_c), 32'h0);
        rst_n = 1'b1;

        // full write then read
        we = 1'b1; wbe = 4'hF; waddr = 8'd5; din = 32'hDEADBEEF; tick();
        we = 1'b0; re = 1'b1; raddr = 8'd5; tick();
        check_vec("full_dout_a", dout_a, 32'hDEADBEEF);
        check_vec("full_vld_a", 32'(vld_a), 32'h1);
        check_vec("full_dout_b", dout_b, 32'hDEADBEEF);
        check_vec("full_vld_c_lat1", 32'(vld_c), 32'h0);
        re = 1'b0; tick();
        check_vec("full_vld_a_pulse", 32'(vld_a), 32'h0);
        check_vec("full_hold_a", dout_a, 32'hDEADBEEF);
        check_vec("full_dout_c", dout_c, 32'hDEADBEEF);
        check_vec("full_vld_c", 32'(vld_c), 32'h1);
        tick();
        check_vec("full_vld_c_pulse", 32'(vld_c), 32'h0);

        // partial writes, including an all-lanes-off write
        we = 1'b1; wbe = 4'hF; waddr = 8'd7; din = 32'h11223344; tick();
        wbe = 4'b0101; din = 32'hAABBCCDD; tick();
        wbe = 4'b0000; din = 32'hFFFFFFFF; tick();
        we = 1'b0; re = 1'b1; raddr = 8'd7; tick();
        check_vec("part_dout_a", dout_a, 32'h11BB33DD);
        check_vec("part_dout_b", dout_b, 32'h11BB33DD);
        re = 1'b0;

        // same-address collision
        we = 1'b1; wbe = 4'hF; waddr = 8'd3; din = 32'h0; tick();
        wbe = 4'b1000; din = 32'hFF000000; re = 1'b1; raddr = 8'd3; tick();
        check_vec("coll_byp_a", dout_a, 32'hFF000000);
        check_vec("coll_nobyp_b", dout_b, 32'h00000000);
        we = 1'b0; tick();
        check_vec("coll_after_a", dout_a, 32'hFF000000);
        check_vec("coll_after_b", dout_b, 32'hFF000000);
        check_vec("coll_byp_c", dout_c, 32'hFF000000);
        we = 1'b1; wbe = 4'b0001; din = 32'h000000AB; tick();
        check_vec("coll_lane_a", dout_a, 32'hFF0000AB);
        check_vec("coll_lane_b", dout_b, 32'hFF000000);
        we = 1'b0; re = 1'b0; tick();
        check_vec("coll_lane_c", dout_c, 32'hFF0000AB);

        // streaming reads over addresses 0..3
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wbe = 4'hF; waddr = 8'(i); din = stream_word(i); tick();
        end
        we = 1'b0; tick(); tick();
        for (int k = 0; k < 6; k++) begin
            re = (k < 4); raddr = 8'(k); tick();
            if (k < 4) begin
                check_vec($sformatf("strm_dout_a%0d", k), dout_a, stream_word(k));
                check_vec($sformatf("strm_vld_a%0d", k), 32'(vld_a), 32'h1);
            end else begin
                check_vec($sformatf("strm_vld_a%0d", k), 32'(vld_a), 32'h0);
            end
            if (k >= 1 && k <= 4) begin
                check_vec($sformatf("strm_dout_c%0d", k), dout_c, stream_word(k - 1));
                check_vec($sformatf("strm_vld_c%0d", k), 32'(vld_c), 32'h1);
            end else begin
                check_vec($sformatf("strm_vld_c%0d", k), 32'(vld_c), 32'h0);
            end
        end
        re = 1'b0;

        // hold with writes to the read address
        re = 1'b1; raddr = 8'd5; tick();
        check_vec("hold_rd_a", dout_a, 32'hDEADBEEF);
        re = 1'b0;
        for (int k = 0; k < 3; k++) begin
            we = 1'b1; wbe = 4'hF; waddr = 8'd5; din = 32'h55550000 | 32'(k); tick();
            check_vec($sformatf("hold_dout_a%0d", k), dout_a, 32'hDEADBEEF);
            check_vec($sformatf("hold_vld_a%0d", k), 32'(vld_a), 32'h0);
            check_vec($sformatf("hold_dout_c%0d", k), dout_c, 32'hDEADBEEF);
            check_vec($sformatf("hold_vld_c%0d", k), 32'(vld_c), (k == 0) ? 32'h1 : 32'h0);
        end
        we = 1'b0;

        // reset in the cycle after a read, with a write attempted during reset
        re = 1'b1; raddr = 8'd7; tick();
        re = 1'b0; rst_n = 1'b0;
        #1;
        check_vec("mrst_dout_a", dout_a, 32'h0);
        check_vec("mrst_vld_a", 32'(vld_a), 32'h0);
        check_vec("mrst_dout_c", dout_c, 32'h0);
        check_vec("mrst_vld_c", 32'(vld_c), 32'h0);
        we = 1'b1; wbe = 4'hF; waddr = 8'd7; din = 32'h0; re = 1'b1; raddr = 8'd7; tick();
        check_vec("mrst_vld_c_in", 32'(vld_c), 32'h0);
        we = 1'b0; re = 1'b0; rst_n = 1'b1; tick();
        check_vec("mrst_vld_c_rel1", 32'(vld_c), 32'h0);
        tick();
        check_vec("mrst_vld_c_rel2", 32'(vld_c), 32'h0);
        check_vec("mrst_dout_c_rel2", dout_c, 32'h0);
        re = 1'b1; raddr = 8'd7; tick();
        check_vec("post_rd7_a", dout_a, 32'h11BB33DD);
        check_vec("post_vld_a", 32'(vld_a), 32'h1);
        raddr = 8'd5; tick();
        check_vec("post_rd5_a", dout_a, 32'h55550002);
        check_vec("post_rd7_c", dout_c, 32'h11BB33DD);
        check_vec("post_vld_c", 32'(vld_c), 32'h1);
        re = 1'b0; tick();
        check_vec("post_rd5_c", dout_c, 32'h55550002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
